// File: rtl/sseg_pkg.sv
// Shared seven-segment types and constants for the display arbiter and its helpers.
package sseg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NUM_REQ    = 2;

  typedef logic [7:0] sseg_t;
  typedef sseg_t [NUM_DIGITS-1:0] sseg_digits_t;

  localparam sseg_t        SSEG_BLANK   = 8'hFF;
  localparam sseg_digits_t DIGITS_BLANK = {NUM_DIGITS{SSEG_BLANK}};

  typedef enum logic {ST_IDLE, ST_OWN} disp_arb_state_t;

  // Hold counter width: enough for 0..n, never narrower than one bit.
  function automatic int unsigned hold_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sseg_disp_arbiter_if.sv
// Requester/display-mux side signals of the seven-segment display arbiter.
interface sseg_disp_arbiter_if
  import sseg_pkg::*;
();
  logic [NUM_REQ-1:0] i_req;
  sseg_digits_t       i_data0_n;
  sseg_digits_t       i_data1_n;
  logic [NUM_REQ-1:0] o_gnt;
  sseg_digits_t       o_digits_n;
  logic               o_busy;

  modport master (
    output i_req, i_data0_n, i_data1_n,
    input  o_gnt, o_digits_n, o_busy
  );

  modport slave (
    input  i_req, i_data0_n, i_data1_n,
    output o_gnt, o_digits_n, o_busy
  );
endinterface

// File: rtl/sseg_tick_gen.sv
// Free-running slow tick: one-clock pulse every 2^TICK_N clocks.
module sseg_tick_gen #(
  parameter int unsigned TICK_N = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [TICK_N-1:0] CNT_PRE = ~TICK_N'(1);

  logic [TICK_N-1:0] r_cnt;
  logic              r_tick;

  // Tick is registered one count early so it is high exactly while the counter is all ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + TICK_N'(1);
      r_tick <= (r_cnt == CNT_PRE);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/sseg_disp_arbiter.sv
// Two-requester round-robin owner of the 4-digit display with a minimum hold time in slow ticks.
module sseg_disp_arbiter
  import sseg_pkg::*;
#(
  parameter int unsigned TICK_N     = 20,
  parameter int unsigned HOLD_TICKS = 50
) (
  input logic                i_clk,
  input logic                i_reset,
  sseg_disp_arbiter_if.slave bus
);

  localparam int unsigned         HOLD_W   = hold_width(HOLD_TICKS);
  localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(HOLD_TICKS);

  disp_arb_state_t    r_state, w_state;
  logic               r_last, w_last;
  logic [HOLD_W-1:0]  r_hold, w_hold;
  logic [NUM_REQ-1:0] r_gnt, w_gnt;
  sseg_digits_t       r_digits, w_digits;
  logic               r_busy, w_busy;

  logic w_tick;
  logic w_grant;
  logic w_sel;

  sseg_tick_gen #(.TICK_N(TICK_N)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_hold   <= '0;
      r_gnt    <= '0;
      r_digits <= DIGITS_BLANK;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_last   <= w_last;
      r_hold   <= w_hold;
      r_gnt    <= w_gnt;
      r_digits <= w_digits;
      r_busy   <= w_busy;
    end
  end

  // While owned, r_last is the current owner, so no separate owner register is kept.
  always_comb begin
    w_state  = r_state;
    w_last   = r_last;
    w_hold   = r_hold;
    w_gnt    = r_gnt;
    w_digits = r_digits;
    w_busy   = r_busy;
    w_grant  = 1'b0;
    w_sel    = r_last;

    case (r_state)
      ST_IDLE: begin
        w_gnt    = '0;
        w_digits = DIGITS_BLANK;
        w_busy   = 1'b0;
        if (|bus.i_req) begin
          w_grant = 1'b1;
          w_sel   = (&bus.i_req) ? ~r_last : bus.i_req[1];
        end
      end
      ST_OWN: begin
        if (!bus.i_req[r_last]) begin
          w_state  = ST_IDLE;
          w_gnt    = '0;
          w_digits = DIGITS_BLANK;
          w_busy   = 1'b0;
        end else if ((r_hold == HOLD_MAX) && bus.i_req[~r_last]) begin
          w_grant = 1'b1;
          w_sel   = ~r_last;
        end else begin
          w_digits = r_last ? bus.i_data1_n : bus.i_data0_n;
          if (w_tick && (r_hold != HOLD_MAX)) begin
            w_hold = r_hold + HOLD_W'(1);
          end
        end
      end
      default: begin
        w_state  = ST_IDLE;
        w_gnt    = '0;
        w_digits = DIGITS_BLANK;
        w_busy   = 1'b0;
      end
    endcase

    // A new grant clears the hold count; a coincident tick is deliberately dropped.
    if (w_grant) begin
      w_state  = ST_OWN;
      w_last   = w_sel;
      w_hold   = '0;
      w_gnt    = w_sel ? 2'b10 : 2'b01;
      w_busy   = 1'b1;
      w_digits = w_sel ? bus.i_data1_n : bus.i_data0_n;
    end
  end

  assign bus.o_gnt      = r_gnt;
  assign bus.o_digits_n = r_digits;
  assign bus.o_busy     = r_busy;

endmodule

// File: tb/tb_sseg_disp_arbiter.sv
// Directed bench for sseg_disp_arbiter with TICK_N=2 (tick every 4 clocks) and HOLD_TICKS=3.
module tb_sseg_disp_arbiter;
  import sseg_pkg::*;

  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;
  localparam logic [31:0] D0A   = 32'hC0F9_A4B0;
  localparam logic [31:0] D0B   = 32'h9282_F880;
  localparam logic [31:0] D1A   = 32'h8883_C6A1;
  localparam logic [31:0] D1B   = 32'h8E86_A1C6;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  gnt;
    logic [31:0] dig;
    logic        busy;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs [10];

  sseg_disp_arbiter_if bus ();

  sseg_disp_arbiter #(.TICK_N(2), .HOLD_TICKS(3)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [31:0] d0, input logic [31:0] d1);
    bus.i_req     = req;
    bus.i_data0_n = d0;
    bus.i_data1_n = d1;
  endtask

  // Inputs are applied during reset so the first edge after release sees them.
  task automatic do_reset(input logic [1:0] req, input logic [31:0] d0, input logic [31:0] d1);
    rst = 1'b1;
    drive(req, d0, d1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic [1:0] req, input logic [31:0] d0, input logic [31:0] d1);
    drive(req, d0, d1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [1:0] gnt, input logic [31:0] dig, input logic busy);
    chk({name, ".gnt"},  32'(bus.o_gnt),      32'(gnt));
    chk({name, ".dig"},  32'(bus.o_digits_n), dig);
    chk({name, ".busy"}, 32'(bus.o_busy),     32'(busy));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(2'b00, D0A, D1A);

    //                req    d0   d1   gnt    digits busy
    vecs[0] = '{2'b00, D0A, D1A, 2'b00, BLANK, 1'b0};
    vecs[1] = '{2'b10, D0A, D1A, 2'b10, D1A,   1'b1};
    vecs[2] = '{2'b10, D0A, D1B, 2'b10, D1B,   1'b1};
    vecs[3] = '{2'b00, D0A, D1B, 2'b00, BLANK, 1'b0};
    vecs[4] = '{2'b11, D0A, D1A, 2'b01, D0A,   1'b1};
    vecs[5] = '{2'b01, D0B, D1A, 2'b01, D0B,   1'b1};
    vecs[6] = '{2'b01, D0A, D1A, 2'b01, D0A,   1'b1};
    vecs[7] = '{2'b00, D0A, D1A, 2'b00, BLANK, 1'b0};
    vecs[8] = '{2'b01, D0A, D1A, 2'b01, D0A,   1'b1};
    vecs[9] = '{2'b11, D0A, D1A, 2'b01, D0A,   1'b1};

    // Reset values while reset is held.
    #12;
    chk_out("reset", 2'b00, BLANK, 1'b0);

    // Table: idle, req1 only, data follow, release, round-robin to 0, data change.
    do_reset(2'b00, D0A, D1A);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].req, vecs[i].d0, vecs[i].d1);
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].dig, vecs[i].busy);
    end

    // Reset asserted mid-grant clears outputs at once; first grant after release in one clock.
    do_reset(2'b01, D0A, D1A);
    step(2'b01, D0A, D1A);
    step(2'b01, D0A, D1A);
    chk_out("pre_rst", 2'b01, D0A, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 2'b00, BLANK, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(2'b01, D0A, D1A);
    chk_out("post_rst", 2'b01, D0A, 1'b1);

    // Contention from reset: ticks land on edges 4,8,12 -> switch at edge 13, back at 25.
    do_reset(2'b11, D0A, D1A);
    for (int c = 1; c <= 26; c++) begin
      step(2'b11, D0A, D1A);
      if (c <= 12 || c >= 25) chk_out($sformatf("rr_c%0d", c), 2'b01, D0A, 1'b1);
      else                    chk_out($sformatf("rr_c%0d", c), 2'b10, D1A, 1'b1);
    end

    // Owner drops after one tick while the other requests: one blank idle cycle.
    do_reset(2'b01, D0A, D1A);
    step(2'b01, D0A, D1A);
    chk_out("drop_c1", 2'b01, D0A, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      step(2'b11, D0A, D1A);
      chk_out($sformatf("drop_c%0d", c), 2'b01, D0A, 1'b1);
    end
    step(2'b10, D0A, D1A);
    chk_out("drop_idle", 2'b00, BLANK, 1'b0);
    step(2'b10, D0A, D1A);
    chk_out("drop_gnt1", 2'b10, D1A, 1'b1);

    // Lone owner for 10 ticks keeps the grant; saturated hold lets a contender in next edge.
    do_reset(2'b01, D0A, D1A);
    for (int c = 1; c <= 40; c++) begin
      step(2'b01, D0A, D1A);
      chk($sformatf("sat_c%0d.gnt", c), 32'(bus.o_gnt), 32'(2'b01));
    end
    step(2'b11, D0A, D1A);
    chk_out("sat_preempt", 2'b10, D1A, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
